// File: rtl/tile_drain_sequencer.sv
// Tile drain sequencer: accepts one SA_N x SA_N int8 tile at a time and drains it
// row by row to a non-backpressured pooling sink, tagging each lane with matrix coordinates.
module tile_drain_sequencer #(
    parameter int SA_N     = 4,
    parameter int MAX_N    = 512,
    parameter int N_BITS   = $clog2(MAX_N + 1),
    parameter int FILTER_H = 2,
    parameter int FILTER_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [N_BITS-1:0]       mat_rows,
    input  logic [N_BITS-1:0]       mat_cols,
    input  logic                    tile_valid,
    input  logic signed [7:0]       tile_data [SA_N][SA_N],
    output logic                    tile_ready,
    input  logic                    sink_idle,
    output logic [N_BITS-1:0]       pos_row,
    output logic [N_BITS-1:0]       pos_col,
    output logic [SA_N-1:0]         out_valid,
    output logic [N_BITS-1:0]       out_row [SA_N],
    output logic [N_BITS-1:0]       out_col [SA_N],
    output logic signed [7:0]       out_data [SA_N],
    output logic                    busy,
    output logic                    done
);

    localparam int R_W = (SA_N > 1) ? $clog2(SA_N) : 1;
    localparam int W1  = N_BITS + 1;

    if (SA_N < FILTER_H || SA_N < FILTER_W || (SA_N & (SA_N - 1)) != 0) begin : g_param_check
        $fatal(1, "SA_N must be a power of two no smaller than the pooling window");
    end

    typedef enum logic [2:0] {IDLE, WAIT_TILE, DRAIN, SETTLE, WAIT_SINK} state_t;

    state_t             state, state_nxt;
    logic [R_W-1:0]     row_cnt;
    logic [N_BITS-1:0]  rows_q, cols_q;
    logic signed [7:0]  tile_q [SA_N][SA_N];
    logic               accept, last_row, last_tile;
    logic [W1-1:0]      row_end, col_end, drain_row;
    logic [W1-1:0]      lane_col [SA_N];

    // One bit of headroom so the bounds compares happen before any wrap
    assign row_end   = {1'b0, pos_row} + W1'(SA_N);
    assign col_end   = {1'b0, pos_col} + W1'(SA_N);
    assign drain_row = {1'b0, pos_row} + W1'(row_cnt);
    assign last_row  = (row_cnt == R_W'(SA_N - 1));
    assign last_tile = (row_end >= {1'b0, rows_q}) && (col_end >= {1'b0, cols_q});
    assign accept    = (state == WAIT_TILE) && tile_valid;

    always_comb begin
        for (int c = 0; c < SA_N; c++) begin
            lane_col[c] = {1'b0, pos_col} + W1'(c);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = WAIT_TILE;
            WAIT_TILE: if (tile_valid) state_nxt = DRAIN;
            DRAIN:     if (last_row) state_nxt = SETTLE;
            SETTLE:    state_nxt = WAIT_SINK;
            WAIT_SINK: if (sink_idle) state_nxt = last_tile ? IDLE : WAIT_TILE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tile_ready = (state == WAIT_TILE);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_q  <= '0;
            cols_q  <= '0;
            pos_row <= '0;
            pos_col <= '0;
            row_cnt <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    rows_q  <= mat_rows;
                    cols_q  <= mat_cols;
                    pos_row <= '0;
                    pos_col <= '0;
                end
                WAIT_TILE: if (tile_valid) row_cnt <= '0;
                DRAIN:     row_cnt <= row_cnt + 1'b1;
                WAIT_SINK: if (sink_idle) begin
                    if (last_tile) begin
                        done <= 1'b1;
                    end else if (col_end >= {1'b0, cols_q}) begin
                        pos_col <= '0;
                        pos_row <= row_end[N_BITS-1:0];
                    end else begin
                        pos_col <= col_end[N_BITS-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) tile_q <= tile_data;
    end

    // Registered lane outputs: one row per DRAIN cycle, suppressed outside the matrix
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= '0;
            for (int c = 0; c < SA_N; c++) begin
                out_row[c]  <= '0;
                out_col[c]  <= '0;
                out_data[c] <= '0;
            end
        end else if (state == DRAIN) begin
            for (int c = 0; c < SA_N; c++) begin
                out_valid[c] <= (drain_row < {1'b0, rows_q}) && (lane_col[c] < {1'b0, cols_q});
                out_row[c]   <= drain_row[N_BITS-1:0];
                out_col[c]   <= lane_col[c][N_BITS-1:0];
                out_data[c]  <= tile_q[row_cnt][c];
            end
        end else begin
            out_valid <= '0;
        end
    end

endmodule

// File: tb/tb_tile_drain_sequencer.sv
// Bench for tile_drain_sequencer: directed matrix passes with a scoreboard of expected drain rows.
module tb_tile_drain_sequencer;

    localparam int SA_N   = 4;
    localparam int N_BITS = 10;

    typedef struct packed {
        logic [SA_N-1:0]             vld;
        logic [SA_N-1:0][N_BITS-1:0] row;
        logic [SA_N-1:0][N_BITS-1:0] col;
        logic [SA_N-1:0][7:0]        data;
    } ev_t;

    logic                clk = 0;
    logic                reset = 1;
    logic                start = 0;
    logic [N_BITS-1:0]   mat_rows = 0;
    logic [N_BITS-1:0]   mat_cols = 0;
    logic                tile_valid = 0;
    logic signed [7:0]   tile_data [SA_N][SA_N];
    logic                tile_ready;
    logic                sink_idle = 1;
    logic [N_BITS-1:0]   pos_row, pos_col;
    logic [SA_N-1:0]     out_valid;
    logic [N_BITS-1:0]   out_row [SA_N];
    logic [N_BITS-1:0]   out_col [SA_N];
    logic signed [7:0]   out_data [SA_N];
    logic                busy, done;

    logic signed [7:0]   cur_tile [SA_N][SA_N];
    ev_t                 exp_q [$];
    int                  n_vec = 0;
    int                  n_err = 0;
    int                  done_cnt = 0;

    tile_drain_sequencer #(.SA_N(SA_N), .MAX_N(512), .N_BITS(N_BITS), .FILTER_H(2), .FILTER_W(2)) dut (
        .clk(clk), .reset(reset), .start(start), .mat_rows(mat_rows), .mat_cols(mat_cols),
        .tile_valid(tile_valid), .tile_data(tile_data), .tile_ready(tile_ready),
        .sink_idle(sink_idle), .pos_row(pos_row), .pos_col(pos_col),
        .out_valid(out_valid), .out_row(out_row), .out_col(out_col), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void fill_tile(int idx);
        for (int r = 0; r < SA_N; r++)
            for (int c = 0; c < SA_N; c++)
                cur_tile[r][c] = 8'(idx * 37 + r * 9 + c * 3 - 50);
    endfunction

    function automatic void push_tile(int pr, int pc, int rows, int cols);
        ev_t e;
        for (int r = 0; r < SA_N; r++) begin
            e = '0;
            for (int c = 0; c < SA_N; c++) begin
                e.vld[c]  = (pr + r < rows) && (pc + c < cols);
                e.row[c]  = N_BITS'(pr + r);
                e.col[c]  = N_BITS'(pc + c);
                e.data[c] = cur_tile[r][c];
            end
            if (e.vld != 0) exp_q.push_back(e);
        end
    endfunction

    // Scoreboard monitor: every presented row must match the next expected row
    always @(negedge clk) begin
        ev_t e;
        bit ok;
        int bad;
        if (!reset && out_valid != 0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_sample_mask", int'(out_valid), 0);
            end else begin
                e = exp_q.pop_front();
                chk("sample_mask", int'(out_valid), int'(e.vld));
                ok = 1;
                bad = 0;
                for (int c = 0; c < SA_N; c++) begin
                    if (ok && (out_row[c] !== e.row[c] || out_col[c] !== e.col[c] ||
                               out_data[c] !== $signed(e.data[c]))) begin
                        ok = 0;
                        bad = c;
                    end
                end
                n_vec++;
                if (!ok) begin
                    n_err++;
                    $display("FAIL sample lane %0d: got row %0d col %0d data %0d, expected row %0d col %0d data %0d",
                             bad, out_row[bad], out_col[bad], out_data[bad],
                             e.row[bad], e.col[bad], $signed(e.data[bad]));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            chk("busy_low_at_done", int'(busy), 0);
        end
    end

    task automatic begin_pass(int rows, int cols);
        @(posedge clk); #1;
        mat_rows = N_BITS'(rows);
        mat_cols = N_BITS'(cols);
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tile_ready) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Returns 1 ns after the accepting edge
    task automatic do_tile(int idx, int pr, int pc, int rows, int cols);
        bit ok;
        fill_tile(idx);
        wait_ready(ok);
        chk("tile_ready_timeout", int'(ok), 1);
        if (ok) begin
            chk("pos_row", int'(pos_row), pr);
            chk("pos_col", int'(pos_col), pc);
            push_tile(pr, pc, rows, cols);
            tile_data = cur_tile;
            tile_valid = 1;
            @(posedge clk); #1;
            tile_valid = 0;
        end
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", int'(seen), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        fill_tile(0);
        tile_data = cur_tile;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_tile_ready", int'(tile_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pos_row", int'(pos_row), 0);
        chk("rst_pos_col", int'(pos_col), 0);
        chk("rst_out_data2", int'(out_data[2]), 0);
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // 8x8, sink always idle
        begin_pass(8, 8);
        chk("busy_after_start", int'(busy), 1);
        do_tile(1, 0, 0, 8, 8);
        do_tile(2, 0, 4, 8, 8);
        do_tile(3, 4, 0, 8, 8);
        do_tile(4, 4, 4, 8, 8);
        wait_done();
        chk("done_count_8x8", done_cnt, 1);

        // 6x6: partial tiles on the right and bottom edges
        begin_pass(6, 6);
        do_tile(5, 0, 0, 6, 6);
        do_tile(6, 0, 4, 6, 6);
        @(posedge clk); #1;
        chk("6x6_t1_mask_row0", int'(out_valid), 4'b0011);
        chk("6x6_t1_col3", int'(out_col[3]), 7);
        do_tile(7, 4, 0, 6, 6);
        do_tile(8, 4, 4, 6, 6);
        @(posedge clk); #1;
        chk("6x6_t3_mask_row4", int'(out_valid), 4'b0011);
        chk("6x6_t3_row_lane0", int'(out_row[0]), 4);
        chk("6x6_t3_col_lane1", int'(out_col[1]), 5);
        @(posedge clk); #1;
        chk("6x6_t3_mask_row5", int'(out_valid), 4'b0011);
        @(posedge clk); #1;
        chk("6x6_t3_mask_row6", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("6x6_t3_mask_row7", int'(out_valid), 0);
        wait_done();
        chk("done_count_6x6", done_cnt, 2);

        // Sink stalls after the first drain
        sink_idle = 0;
        begin_pass(8, 8);
        do_tile(9, 0, 0, 8, 8);
        repeat (5) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_tile_ready", int'(tile_ready), 0);
        end
        chk("stall_pos_row", int'(pos_row), 0);
        chk("stall_pos_col", int'(pos_col), 0);
        @(posedge clk); #1;
        sink_idle = 1;
        chk("stall_ready_same_cycle", int'(tile_ready), 0);
        @(posedge clk); #1;
        chk("stall_ready_next_cycle", int'(tile_ready), 1);
        chk("stall_advanced_col", int'(pos_col), 4);
        do_tile(10, 0, 4, 8, 8);
        do_tile(11, 4, 0, 8, 8);
        do_tile(12, 4, 4, 8, 8);
        wait_done();
        chk("done_count_stall", done_cnt, 3);

        // Extreme int8 values and drain timing
        begin_pass(4, 4);
        fill_tile(13);
        cur_tile[2][1] = -128;
        cur_tile[3][3] = 127;
        begin
            bit ok;
            wait_ready(ok);
            chk("special_ready", int'(ok), 1);
            push_tile(0, 0, 4, 4);
            tile_data = cur_tile;
            tile_valid = 1;
            @(posedge clk); #1;
            tile_valid = 0;
        end
        repeat (3) @(posedge clk); #1;
        chk("special_T3_lane1", int'(out_data[1]), -128);
        chk("special_T3_row", int'(out_row[1]), 2);
        @(posedge clk); #1;
        chk("special_T4_lane3", int'(out_data[3]), 127);
        @(posedge clk); #1;
        chk("special_T5_valid", int'(out_valid), 0);
        wait_done();
        chk("done_count_special", done_cnt, 4);

        // Asynchronous reset in the middle of the second drain
        begin_pass(8, 8);
        do_tile(1, 0, 0, 8, 8);
        do_tile(1, 0, 4, 8, 8);
        @(posedge clk);
        #3 reset = 1;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_col3", int'(out_col[3]), 0);
        chk("midrst_out_data0", int'(out_data[0]), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_tile_ready", int'(tile_ready), 0);
        chk("midrst_pos_col", int'(pos_col), 0);
        repeat (2) @(posedge clk); #1;
        reset = 0;
        chk("midrst_idle_busy", int'(busy), 0);
        begin_pass(4, 4);
        do_tile(14, 0, 0, 4, 4);
        wait_done();
        chk("done_count_after_reset", done_cnt, 5);

        // tile_valid in IDLE and start during DRAIN are ignored
        tile_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_tile_ready", int'(tile_ready), 0);
            chk("idle_busy", int'(busy), 0);
        end
        @(posedge clk); #1;
        tile_valid = 0;
        begin_pass(8, 4);
        do_tile(15, 0, 0, 8, 4);
        mat_rows = 4;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("start_in_drain_busy", int'(busy), 1);
        chk("start_in_drain_pos_row", int'(pos_row), 0);
        do_tile(16, 4, 0, 8, 4);
        wait_done();
        chk("done_count_final", done_cnt, 6);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t, expected completion earlier", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tile_drain_sequencer.md
Name: tile_drain_sequencer

Overview:
- Producer-side counterpart of the pooling sink. Walks an output matrix tile by tile in SA_N x SA_N steps.
- Accepts one post-requant int8 tile per step from the tile buffer through a valid/ready handshake.
- Drains each tile one row per cycle across SA_N lanes, tagging every element with absolute row/col and holding the tile base (pos_row/pos_col) stable.
- Does not accept the next tile until the downstream sink reports idle, because the sink has no backpressure.

Parameters:
SA_N, 4, lane count and tile dimension; power of two, >= FILTER_H and FILTER_W.
MAX_N, 512, maximum matrix dimension.
N_BITS, $clog2(MAX_N+1), width of dimensions and coordinates.
FILTER_H, 2, sink pooling window height; mat_rows must be a multiple of it.
FILTER_W, 2, sink pooling window width; mat_cols must be a multiple of it.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a matrix pass; ignored unless in IDLE
mat_rows  input  N_BITS  matrix rows; sampled on accepted start; range 1..MAX_N
mat_cols  input  N_BITS  matrix cols; sampled on accepted start; range 1..MAX_N
tile_valid  input  1  tile_data is valid
tile_data  input  int8_t [SA_N][SA_N]  tile, indexed [row][col]
tile_ready  output  1  block will accept a tile this cycle
sink_idle  input  1  downstream pooling sink has no pending samples
pos_row  output  N_BITS  current tile base row
pos_col  output  N_BITS  current tile base col
out_valid  output  1 [SA_N]  per-lane sample valid
out_row  output  N_BITS [SA_N]  per-lane absolute row
out_col  output  N_BITS [SA_N]  per-lane absolute col
out_data  output  int8_t [SA_N]  per-lane sample
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the last tile has been drained and the sink has settled

Behaviour:
- Reset values: all outputs 0; all out_valid lanes 0; FSM in IDLE; cursor (0,0); row counter 0. Reset is asynchronous, takes effect mid-pass, and discards any latched tile.
- FSM states: IDLE, WAIT_TILE, DRAIN, SETTLE, WAIT_SINK.
- IDLE:
  - On start, latch mat_rows and mat_cols, set pos_row = pos_col = 0, and go to WAIT_TILE.
  - tile_valid is ignored in IDLE.
- WAIT_TILE:
  - tile_ready = 1, driven combinationally from state.
  - On tile_valid & tile_ready, latch tile_data, clear the row counter, and go to DRAIN.
- DRAIN lasts exactly SA_N cycles. For row counter r = 0..SA_N-1 and each lane c:
  - out_row[c] = pos_row + r
  - out_col[c] = pos_col + c
  - out_data[c] = tile[r][c]
  - out_valid[c] = (pos_row + r < mat_rows) && (pos_col + c < mat_cols)
  - Outputs are registered: a tile accepted at edge T presents row 0 in cycle T+1 and row SA_N-1 in cycle T+SA_N.
  - A row lying entirely outside the matrix still consumes its cycle, with all lanes invalid.
- Out-of-bounds samples are suppressed, so only whole FILTER_H x FILTER_W blocks are ever emitted (this relies on the multiple-of-filter constraints on mat_rows/mat_cols).
- DRAIN exit: after the last row, all out_valid lanes drop to 0 and the FSM goes to SETTLE.
- SETTLE is one guard cycle. It covers the sink's one-cycle write latency; sink_idle is ignored during it. Then go to WAIT_SINK.
- WAIT_SINK: hold until sink_idle = 1. pos_row and pos_col stay unchanged from WAIT_TILE through WAIT_SINK.
  - If this was the last tile (pos_row + SA_N >= mat_rows and pos_col + SA_N >= mat_cols): pulse done for one cycle, then go to IDLE.
  - Otherwise advance the cursor and go to WAIT_TILE.
- Cursor advance:
  - pos_col += SA_N.
  - If the new pos_col >= mat_cols, set pos_col = 0 and pos_row += SA_N (row-major tile order).
  - Arithmetic is N_BITS wide; the compare is done before the add can wrap.
- Other conditions:
  - start outside IDLE is ignored.
  - tile_valid outside WAIT_TILE is ignored; the producer must hold the tile until it is accepted.

Test Plan:
- SA_N=4, mat 8x8, sink_idle tied 1 -> 4 tiles with pos sequence (0,0),(0,4),(4,0),(4,4); each tile gives 4 DRAIN cycles with all lanes valid; out_row/out_col on each lane match the absolute coordinates; done pulses once; busy drops with done.
- mat 6x6 -> tile (4,4) drives lanes 0-1 valid in rows 4-5 and all lanes invalid in rows 6-7; tile (0,4) drives lanes 2-3 invalid; 4 tiles total.
- Hold sink_idle=0 for 10 cycles after the first drain -> tile_ready stays 0 and pos stays (0,0); tile_ready rises in the cycle after sink_idle goes high.
- Tile with tile[2][1]=-128 and tile[3][3]=127, accepted at edge T -> lane 1 carries -128 at T+3; lane 3 carries 127 at T+4; all out_valid lanes are 0 at T+5 (SETTLE).
- Assert reset mid-DRAIN of the second tile -> all outputs 0 immediately; FSM in IDLE; a fresh start with mat 4x4 gives a single tile, then done.
- start pulsed during DRAIN, and tile_valid asserted in IDLE -> both ignored; pos unchanged; no extra tile accepted.
